urna_ctrl: RTL

Voting-session controller for the three-voter ballot datapath. It opens a session on `start` and accepts at most one vote per voter through a valid/ack handshake. It closes the session when all three voters have voted or when a cycle timeout expires, then publishes the latched vote vector and a registered tally. It is the sequencing layer between the voter inputs and the combinational vote tally.

---
 rtl/urna_ctrl_pkg.sv | 19 +
 rtl/urna_ctrl_tally3.sv | 23 ++
 rtl/urna_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/urna_ctrl_pkg.sv
// Shared types and constants for the three-voter ballot controller.
package urna_pkg;

  localparam int N_VOTERS = 3;

  // Bit positions inside the 4-bit result word
  localparam int R_CNT_LO     = 0;
  localparam int R_CNT_HI     = 1;
  localparam int R_APPROVED   = 2;
  localparam int R_INCOMPLETE = 3;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    TALLY,
    DONE
  } state_t;

endpackage

// File: rtl/urna_ctrl_tally3.sv
// Combinational tally: yes count, approval and incompleteness flags.
module tally3
  import urna_pkg::*;
(
  input  logic [2:0] V,
  input  logic [2:0] voted,
  output logic [3:0] R
);

  logic [2:0] yes_votes;
  logic [1:0] yes_cnt;

  always_comb begin
    // Anyone who did not vote counts as not-yes
    yes_votes = V & voted;
    yes_cnt   = {1'b0, yes_votes[0]} + {1'b0, yes_votes[1]} + {1'b0, yes_votes[2]};
    R                       = '0;
    R[R_CNT_HI:R_CNT_LO]    = yes_cnt;
    R[R_APPROVED]           = yes_cnt[1];
    R[R_INCOMPLETE]         = ~&voted;
  end

endmodule

// File: rtl/urna_ctrl.sv
// Voting-session controller: opens on start, collects one vote per voter,
// closes on full vote set or timeout, then publishes a registered tally.
module urna_ctrl
  import urna_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] vote_valid,
  input  logic [2:0] vote_yes,
  output logic [2:0] vote_ack,
  output logic [2:0] voted,
  output logic       busy,
  output logic       done,
  output logic [2:0] V,
  output logic [3:0] R
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       voted_q, voted_d;
  logic [2:0]       v_q, v_d;
  logic [3:0]       r_q, r_d;
  logic [2:0]       ack_q, ack_d;
  logic [2:0]       accept;
  logic [3:0]       tally_r;

  tally3 u_tally (
    .V     (v_q),
    .voted (voted_q),
    .R     (tally_r)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    voted_d = voted_q;
    v_d     = v_q;
    r_d     = r_q;
    ack_d   = '0;
    accept  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = OPEN;
          voted_d = '0;
          v_d     = '0;
          timer_d = '0;
        end
      end
      OPEN: begin
        accept  = vote_valid & ~voted_q;
        voted_d = voted_q | accept;
        v_d     = (v_q & ~accept) | (vote_yes & accept);
        ack_d   = accept;
        timer_d = timer_q + 1'b1;
        // A vote landing on the final timeout cycle still completes the set
        if (&voted_d || timer_q == TMR_LAST) begin
          state_d = TALLY;
        end
      end
      TALLY: begin
        r_d     = tally_r;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      voted_q <= '0;
      v_q     <= '0;
      r_q     <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      voted_q <= voted_d;
      v_q     <= v_d;
      r_q     <= r_d;
      ack_q   <= ack_d;
    end
  end

  assign vote_ack = ack_q;
  assign voted    = voted_q;
  assign V        = v_q;
  assign R        = r_q;
  assign busy     = (state_q == OPEN) || (state_q == TALLY);
  assign done     = (state_q == DONE);

endmodule
